seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width, derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 op  input  4  operation select (REQ-012).
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH; zero, lt, ltu, gt, illegal  output  1 each; busy  output  1.

Function
REQ-012 SHALL decode op: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 slt, 6 srl, 7 xor, 8 sra, 9 sltu, 10 mul (low WIDTH bits), 11 mulhu (high WIDTH bits, unsigned), 12 divu, 13 remu, 14-15 reserved.
REQ-013 SHALL take shift amount from b[SHW-1:0] only; upper b bits ignored.
REQ-014 SHALL compute add/sub modulo 2^WIDTH; slt/sltu produce 1 or 0 zero-extended to WIDTH.
REQ-015 SHALL compute flags from a-b for every op, registered with result: zero = (result == 0); lt = signed a<b (overflow-corrected); ltu = unsigned a<b; gt = signed a>b (a-b positive and nonzero with overflow correction).
REQ-016 SHALL implement mul/mulhu as iterative shift-add, one partial product per cycle, WIDTH iterations.
REQ-017 SHALL implement divu/remu as iterative restoring division, one quotient bit per cycle, WIDTH iterations.
REQ-018 Divide by zero: divu result all ones, remu result = a; no extra cycles, no error flag.
REQ-019 Reserved op: result 0, illegal=1, single-cycle latency; illegal=0 for all legal ops.
REQ-020 SHALL use FSM states IDLE, BUSY, DONE.
REQ-021 IDLE: in_ready=1; on in_valid, capture op/a/b; single-cycle op -> DONE with result registered on the accepting edge; iterative op -> BUSY, iteration counter loaded with WIDTH-1.
REQ-022 BUSY: in_ready=0, busy=1; one iteration per edge; counter decrements; edge with counter==0 completes last iteration and moves to DONE.
REQ-023 Latency (accepting edge to first edge out_valid observed high): single-cycle ops 1, iterative ops WIDTH+1.
REQ-024 DONE: out_valid=1; result and flags held stable until out_ready=1.
REQ-025 DONE with out_ready=1 and in_valid=0 -> IDLE; with out_ready=1 and in_valid=1 -> new operation accepted same edge (in_ready=out_ready in DONE), giving back-to-back single-cycle throughput of one op per clock.
REQ-026 Operands changing on a/b/op while BUSY or DONE SHALL NOT affect in-flight result.
REQ-027 in_valid while in_ready=0 SHALL be ignored; no queueing.
REQ-028 busy SHALL be 1 only in BUSY.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE from any state, abandoning any in-flight operation with no result delivered.
REQ-030 Output values after reset: in_ready=1, out_valid=0, busy=0, result=0, zero=0, lt=0, ltu=0, gt=0, illegal=0, iteration counter=0.
REQ-031 in_valid asserted during a reset cycle SHALL NOT be accepted.

Verification
REQ-032 WIDTH=32, op=1, a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=0xFFFFFFFE, lt=1, ltu=1, gt=0, zero=0.
REQ-033 op=8 (sra), a=0x80000000, b=0x00000024 -> result=0xF8000000 (shift 4, upper b ignored); op=4 same operands -> 0x00000000.
REQ-034 op=11, a=b=0xFFFFFFFF -> out_valid exactly 33 edges after acceptance, result=0xFFFFFFFE, busy high 32 cycles, in_ready low meanwhile.
REQ-035 op=12, a=100, b=0 -> result=0xFFFFFFFF; op=13 same -> result=100; op=12, a=100, b=7 -> 14; op=13 -> 2.
REQ-036 Hold out_ready=0 for 5 cycles in DONE while toggling a/b/op -> result/flags unchanged; then out_ready=1 with in_valid=1, op=0, a=1, b=1 -> accepted same edge, next cycle result=2.
REQ-037 Assert reset mid-BUSY (cycle 10 of mul) -> next cycle IDLE, out_valid=0, busy=0, in_ready=1; subsequent op=15 -> result=0, illegal=1.

Source files
------------

// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_alu                                                       |
// | Purpose  : Sequential ALU with ready/valid handshake. Simple ops finish  |
// |            in one cycle; mul/mulhu use shift-add and divu/remu use       |
// |            restoring division, one step per clock for WIDTH steps.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             lt,
   output logic             ltu,
   output logic             gt,
   output logic             illegal,
   output logic             busy
);

   localparam logic [3:0] c_OP_ADD   = 4'd0;
   localparam logic [3:0] c_OP_SUB   = 4'd1;
   localparam logic [3:0] c_OP_AND   = 4'd2;
   localparam logic [3:0] c_OP_OR    = 4'd3;
   localparam logic [3:0] c_OP_SLL   = 4'd4;
   localparam logic [3:0] c_OP_SLT   = 4'd5;
   localparam logic [3:0] c_OP_SRL   = 4'd6;
   localparam logic [3:0] c_OP_XOR   = 4'd7;
   localparam logic [3:0] c_OP_SRA   = 4'd8;
   localparam logic [3:0] c_OP_SLTU  = 4'd9;
   localparam logic [3:0] c_OP_MUL   = 4'd10;
   localparam logic [3:0] c_OP_MULHU = 4'd11;
   localparam logic [3:0] c_OP_DIVU  = 4'd12;
   localparam logic [3:0] c_OP_REMU  = 4'd13;

   localparam logic [SHW-1:0] c_CNT_LOAD = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_hi;      // product high half / partial remainder
   logic [WIDTH-1:0] r_lo;      // multiplier bits / dividend-quotient bits
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_lt;
   logic             r_ltu;
   logic             r_gt;
   logic             r_illegal;

   logic             w_accept;
   logic             w_is_iter;
   logic             w_is_rsvd;
   logic             w_op_div_in;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_alu_res;
   logic [2:0]       w_in_flags;
   logic [2:0]       w_cap_flags;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH:0]   w_div_diff;
   logic             w_div_ge;
   logic             w_cap_div;
   logic [WIDTH-1:0] w_nxt_hi;
   logic [WIDTH-1:0] w_nxt_lo;
   logic [WIDTH-1:0] w_iter_res;

   // Compare flags derived from a-b: {signed lt, unsigned lt, signed gt}.
   // Signed lt uses the sign of the difference corrected for overflow.
   function automatic logic [2:0] cmp_flags(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
      logic [WIDTH:0] w_d;
      logic           w_ovf;
      logic           w_slt;
      w_d   = {1'b0, x} - {1'b0, y};
      w_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (w_d[WIDTH-1] != x[WIDTH-1]);
      w_slt = w_d[WIDTH-1] ^ w_ovf;
      return {w_slt, w_d[WIDTH], !w_slt && (w_d[WIDTH-1:0] != '0)};
   endfunction

   assign in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign out_valid   = (r_state == DONE);
   assign busy        = (r_state == BUSY);
   assign result      = r_result;
   assign zero        = r_zero;
   assign lt          = r_lt;
   assign ltu         = r_ltu;
   assign gt          = r_gt;
   assign illegal     = r_illegal;

   assign w_accept    = in_valid && in_ready;
   assign w_is_iter   = (op >= c_OP_MUL) && (op <= c_OP_REMU);
   assign w_is_rsvd   = (op > c_OP_REMU);
   assign w_op_div_in = (op == c_OP_DIVU) || (op == c_OP_REMU);
   assign w_shamt     = b[SHW-1:0];
   assign w_in_flags  = cmp_flags(a, b);
   assign w_cap_flags = cmp_flags(r_a, r_b);

   // Single-cycle result straight from the presented operands.
   always_comb begin
      w_alu_res = '0;
      case (op)
         c_OP_ADD:  w_alu_res = a + b;
         c_OP_SUB:  w_alu_res = a - b;
         c_OP_AND:  w_alu_res = a & b;
         c_OP_OR:   w_alu_res = a | b;
         c_OP_SLL:  w_alu_res = a << w_shamt;
         c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         c_OP_SRL:  w_alu_res = a >> w_shamt;
         c_OP_XOR:  w_alu_res = a ^ b;
         c_OP_SRA:  w_alu_res = $signed(a) >>> w_shamt;
         c_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default:   w_alu_res = '0;
      endcase
   end

   // One iteration step: shift-add for multiply, restoring step for divide.
   always_comb begin
      w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
      w_div_shift = {r_hi, r_lo[WIDTH-1]};
      w_div_diff  = w_div_shift - {1'b0, r_b};
      w_div_ge    = !w_div_diff[WIDTH];
      w_cap_div   = (r_op == c_OP_DIVU) || (r_op == c_OP_REMU);
      if (w_cap_div) begin
         w_nxt_hi = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
         w_nxt_lo = {r_lo[WIDTH-2:0], w_div_ge};
      end else begin
         w_nxt_hi = w_mul_sum[WIDTH:1];
         w_nxt_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end
      // mulhu and remu take the high/remainder half, mul and divu the low/quotient half
      w_iter_res = ((r_op == c_OP_MULHU) || (r_op == c_OP_REMU)) ? w_nxt_hi : w_nxt_lo;
   end

   // Control FSM with captured operands, iteration datapath and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_lt      <= 1'b0;
         r_ltu     <= 1'b0;
         r_gt      <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_op <= op;
                  r_a  <= a;
                  r_b  <= b;
                  if (w_is_iter) begin
                     r_state <= BUSY;
                     r_cnt   <= c_CNT_LOAD;
                     r_hi    <= '0;
                     r_lo    <= w_op_div_in ? a : b;
                  end else begin
                     r_state   <= DONE;
                     r_result  <= w_alu_res;
                     r_zero    <= (w_alu_res == '0);
                     r_lt      <= w_in_flags[2];
                     r_ltu     <= w_in_flags[1];
                     r_gt      <= w_in_flags[0];
                     r_illegal <= w_is_rsvd;
                  end
               end else if ((r_state == DONE) && out_ready) begin
                  r_state <= IDLE;
               end
            end
            BUSY: begin
               r_hi <= w_nxt_hi;
               r_lo <= w_nxt_lo;
               if (r_cnt == '0) begin
                  r_state   <= DONE;
                  r_result  <= w_iter_res;
                  r_zero    <= (w_iter_res == '0);
                  r_lt      <= w_cap_flags[2];
                  r_ltu     <= w_cap_flags[1];
                  r_gt      <= w_cap_flags[0];
                  r_illegal <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - SHW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_alu                                                    |
// | Purpose  : Directed self-checking bench for seq_alu (WIDTH = 32).        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero, lt, ltu, gt, illegal, busy;

   int chk = 0;
   int err = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        lt;
      logic        ltu;
      logic        gt;
      logic        ill;
   } vec_t;

   seq_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .lt        (lt),
      .ltu       (ltu),
      .gt        (gt),
      .illegal   (illegal),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Present one op from IDLE, scramble operands after acceptance, wait for out_valid.
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int nbusy, output int nrdy);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; op = ~o; a = ~x; b = y ^ 32'h5A5A_A5A5;
      lat = 1; nbusy = 0; nrdy = 0;
      while (!out_valid && lat < 100) begin
         if (busy) nbusy++;
         if (in_ready) nrdy++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      chk++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      chk++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      chk++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      chk++; if (result !== 32'h0) begin err++; $display("FAIL reset_result: got %h expected 00000000", result); end
      chk++; if ({zero, lt, ltu, gt, illegal} !== 5'b0) begin err++; $display("FAIL reset_flags: got %b expected 00000", {zero, lt, ltu, gt, illegal}); end
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      chk++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_no_accept: got out_valid %b expected 0", out_valid); end
   endtask

   task automatic test_single_cycle();
      vec_t v[17];
      int   lat, nb, nr;
      v[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
      v[1]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      v[2]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b0};
      v[3]  = '{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b1, 1'b0, 1'b0, 1'b0};
      v[4]  = '{4'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b1, 1'b0, 1'b0, 1'b0};
      v[5]  = '{4'd7,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b1, 1'b0, 1'b0, 1'b0};
      v[6]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
      v[7]  = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      v[8]  = '{4'd5,  32'h00000009, 32'h00000009, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
      v[9]  = '{4'd8,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b1, 1'b0, 1'b0, 1'b0};
      v[10] = '{4'd4,  32'h80000000, 32'h00000024, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      v[11] = '{4'd6,  32'h80000000, 32'h00000024, 32'h08000000, 1'b1, 1'b0, 1'b0, 1'b0};
      v[12] = '{4'd4,  32'h00000003, 32'hFFFFFFE1, 32'h00000006, 1'b0, 1'b1, 1'b1, 1'b0};
      v[13] = '{4'd8,  32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      v[14] = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
      v[15] = '{4'd1,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
      v[16] = '{4'd14, 32'h00000003, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 17; i++) begin
         issue(v[i].op, v[i].a, v[i].b, lat, nb, nr);
         chk++; if (lat !== 1) begin err++; $display("FAIL alu%0d_latency: got %0d expected 1", i, lat); end
         chk++; if (result !== v[i].r) begin err++; $display("FAIL alu%0d_result: got %h expected %h", i, result, v[i].r); end
         chk++; if (zero !== (v[i].r == 32'h0)) begin err++; $display("FAIL alu%0d_zero: got %b expected %b", i, zero, (v[i].r == 32'h0)); end
         chk++; if ({lt, ltu, gt} !== {v[i].lt, v[i].ltu, v[i].gt}) begin err++; $display("FAIL alu%0d_flags: got lt/ltu/gt %b expected %b", i, {lt, ltu, gt}, {v[i].lt, v[i].ltu, v[i].gt}); end
         chk++; if (illegal !== v[i].ill) begin err++; $display("FAIL alu%0d_illegal: got %b expected %b", i, illegal, v[i].ill); end
         release_out();
      end
   endtask

   task automatic test_iterative();
      vec_t v[10];
      int   lat, nb, nr;
      v[0] = '{4'd10, 32'd1000,      32'd1000,      32'h000F4240, 1'b0, 1'b0, 1'b0, 1'b0};
      v[1] = '{4'd10, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
      v[2] = '{4'd11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
      v[3] = '{4'd11, 32'h80000000,  32'h00000004,  32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
      v[4] = '{4'd12, 32'd100,       32'd0,         32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      v[5] = '{4'd13, 32'd100,       32'd0,         32'd100,      1'b0, 1'b0, 1'b1, 1'b0};
      v[6] = '{4'd12, 32'd100,       32'd7,         32'd14,       1'b0, 1'b0, 1'b1, 1'b0};
      v[7] = '{4'd13, 32'd100,       32'd7,         32'd2,        1'b0, 1'b0, 1'b1, 1'b0};
      v[8] = '{4'd12, 32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
      v[9] = '{4'd13, 32'd7,         32'd100,       32'd7,        1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         issue(v[i].op, v[i].a, v[i].b, lat, nb, nr);
         chk++; if (lat !== 33) begin err++; $display("FAIL iter%0d_latency: got %0d expected 33", i, lat); end
         chk++; if (nb !== 32) begin err++; $display("FAIL iter%0d_busy_cycles: got %0d expected 32", i, nb); end
         chk++; if (nr !== 0) begin err++; $display("FAIL iter%0d_in_ready_while_busy: got %0d cycles expected 0", i, nr); end
         chk++; if (result !== v[i].r) begin err++; $display("FAIL iter%0d_result: got %h expected %h", i, result, v[i].r); end
         chk++; if ({zero, lt, ltu, gt, illegal} !== {(v[i].r == 32'h0), v[i].lt, v[i].ltu, v[i].gt, 1'b0}) begin err++; $display("FAIL iter%0d_flags: got z/lt/ltu/gt/ill %b expected %b", i, {zero, lt, ltu, gt, illegal}, {(v[i].r == 32'h0), v[i].lt, v[i].ltu, v[i].gt, 1'b0}); end
         release_out();
      end
   endtask

   task automatic test_hold();
      int lat, nb, nr;
      issue(4'd1, 32'd5, 32'd7, lat, nb, nr);
      for (int i = 0; i < 5; i++) begin
         op = 4'(i + 2); a = $urandom; b = $urandom; in_valid = 1'b1;
         @(posedge clk); #1;
         chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin err++; $display("FAIL hold%0d_handshake: got out_valid %b in_ready %b expected 1 0", i, out_valid, in_ready); end
         chk++; if (result !== 32'hFFFFFFFE || {zero, lt, ltu, gt} !== 4'b0110) begin err++; $display("FAIL hold%0d_stable: got %h z/lt/ltu/gt %b expected fffffffe 0110", i, result, {zero, lt, ltu, gt}); end
      end
      out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      chk++; if (out_valid !== 1'b1 || result !== 32'd2) begin err++; $display("FAIL hold_next_accept: got out_valid %b result %h expected 1 00000002", out_valid, result); end
      chk++; if ({zero, lt, ltu, gt} !== 4'b0000) begin err++; $display("FAIL hold_next_flags: got %b expected 0000", {zero, lt, ltu, gt}); end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk++; if (out_valid !== 1'b0) begin err++; $display("FAIL hold_drain: got out_valid %b expected 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0]  vo[4] = '{4'd0, 4'd1, 4'd7, 4'd3};
      logic [31:0] va[4] = '{32'd1, 32'd10, 32'h000000FF, 32'h00001200};
      logic [31:0] vb[4] = '{32'd2, 32'd3, 32'h0000000F, 32'h00000034};
      logic [31:0] vr[4] = '{32'd3, 32'd7, 32'h000000F0, 32'h00001234};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; op = vo[i]; a = va[i]; b = vb[i];
         @(posedge clk); #1;
         chk++; if (out_valid !== 1'b1 || result !== vr[i]) begin err++; $display("FAIL b2b%0d: got out_valid %b result %h expected 1 %h", i, out_valid, result, vr[i]); end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin err++; $display("FAIL b2b_idle: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_busy();
      int lat, nb, nr;
      op = 4'd10; a = 32'h1234; b = 32'h10; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk++; if (busy !== 1'b1) begin err++; $display("FAIL rstbusy_pre: got busy %b expected 1", busy); end
      reset = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      chk++; if ({out_valid, busy, in_ready} !== 3'b001) begin err++; $display("FAIL rstbusy_state: got out_valid/busy/in_ready %b expected 001", {out_valid, busy, in_ready}); end
      chk++; if (result !== 32'h0 || illegal !== 1'b0) begin err++; $display("FAIL rstbusy_outputs: got result %h illegal %b expected 00000000 0", result, illegal); end
      reset = 1'b0; in_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk++; if (out_valid !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL rstbusy_abandoned: got out_valid %b busy %b expected 0 0", out_valid, busy); end
      issue(4'd15, 32'h3, 32'h5, lat, nb, nr);
      chk++; if (lat !== 1 || result !== 32'h0 || illegal !== 1'b1) begin err++; $display("FAIL rstbusy_reserved: got lat %0d result %h illegal %b expected 1 00000000 1", lat, result, illegal); end
      release_out();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      test_reset();
      test_single_cycle();
      test_iterative();
      test_hold();
      test_back_to_back();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule
`default_nettype wire
